// File: rtl/tlb_fill_ctrl.sv
// TLB miss-handling controller: arbitrates ITLB/DTLB misses, walks one PTE per
// miss over a single read port and writes the built entry at a round-robin index.
module tlb_fill_ctrl #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned IDX_W   = 3,
  localparam int unsigned PTBR_W  = 10,
  localparam int unsigned VPN_W   = 20,
  localparam int unsigned ADDR_W  = 32,
  localparam int unsigned DATA_W  = 32,
  localparam int unsigned ENTRY_W = 44
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PTBR_W-1:0]  PTBR,
  input  logic               ITLB_MISS,
  input  logic [VPN_W-1:0]   ITLB_VPN,
  input  logic               DTLB_MISS,
  input  logic [VPN_W-1:0]   DTLB_VPN,
  output logic               MEM_REQ,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  input  logic               MEM_READY,
  input  logic [DATA_W-1:0]  MEM_DATA,
  output logic [ENTRY_W-1:0] FILL_ENTRY,
  output logic               ITLB_FILL_EN,
  output logic               DTLB_FILL_EN,
  output logic [IDX_W-1:0]   ITLB_FILL_IDX,
  output logic [IDX_W-1:0]   DTLB_FILL_IDX,
  output logic               ITLB_DONE,
  output logic               DTLB_DONE,
  output logic               PAGE_FAULT,
  output logic               FAULT_SRC
);

  localparam int unsigned FRAME_W = 20;
  localparam logic SRC_ITLB = 1'b0;
  localparam logic SRC_DTLB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  typedef struct packed {
    logic [FRAME_W-1:0] frame;
    logic               pcd;
    logic               rw;
    logic               p;
  } pte_t;

  typedef struct packed {
    logic [VPN_W-1:0]   vpn;
    logic [FRAME_W-1:0] rpn;
    logic               v;
    logic               pre;
    logic               rw;
    logic               pcd;
  } tlb_entry_t;

  state_t             state_q, state_d;
  logic               src_q, src_d;
  logic               last_src_q, last_src_d;
  logic [VPN_W-1:0]   vpn_q, vpn_d;
  pte_t               pte_q, pte_d;
  logic [IDX_W-1:0]   itlb_idx_q, itlb_idx_d;
  logic [IDX_W-1:0]   dtlb_idx_q, dtlb_idx_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  tlb_entry_t         fill_entry_q, fill_entry_d;
  logic               itlb_fill_en_q, itlb_fill_en_d;
  logic               dtlb_fill_en_q, dtlb_fill_en_d;
  logic               itlb_done_q, itlb_done_d;
  logic               dtlb_done_q, dtlb_done_d;
  logic               page_fault_q, page_fault_d;
  logic               fault_src_q, fault_src_d;

  logic               grant_dtlb;
  pte_t               mem_pte;
  logic               unused_mem_bits;

  assign mem_pte = '{frame: MEM_DATA[31:12], pcd: MEM_DATA[4],
                     rw: MEM_DATA[1], p: MEM_DATA[0]};
  assign unused_mem_bits = ^{MEM_DATA[11:5], MEM_DATA[3:2]};

  // On a tie the requester that was not served last wins.
  assign grant_dtlb = DTLB_MISS && (!ITLB_MISS || (last_src_q == SRC_ITLB));

  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(ENTRIES - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    last_src_d     = last_src_q;
    vpn_d          = vpn_q;
    pte_d          = pte_q;
    itlb_idx_d     = itlb_idx_q;
    dtlb_idx_d     = dtlb_idx_q;
    mem_addr_d     = mem_addr_q;
    fill_entry_d   = fill_entry_q;
    fault_src_d    = fault_src_q;
    mem_req_d      = 1'b0;
    itlb_fill_en_d = 1'b0;
    dtlb_fill_en_d = 1'b0;
    itlb_done_d    = 1'b0;
    dtlb_done_d    = 1'b0;
    page_fault_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ITLB_MISS || DTLB_MISS) begin
          src_d   = grant_dtlb ? SRC_DTLB : SRC_ITLB;
          vpn_d   = grant_dtlb ? DTLB_VPN : ITLB_VPN;
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        if (MEM_READY) begin
          pte_d   = mem_pte;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        last_src_d = src_q;
        if (pte_q.p) begin
          if (src_q == SRC_DTLB) dtlb_idx_d = idx_next(dtlb_idx_q);
          else                   itlb_idx_d = idx_next(itlb_idx_q);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    if (state_d == ST_WALK) begin
      mem_req_d  = 1'b1;
      mem_addr_d = {PTBR, vpn_d, 2'b00};
    end

    if (state_d == ST_FILL) begin
      fill_entry_d = '{vpn: vpn_d, rpn: pte_d.frame, v: 1'b1,
                       pre: pte_d.p, rw: pte_d.rw, pcd: pte_d.pcd};
      itlb_done_d  = (src_d == SRC_ITLB);
      dtlb_done_d  = (src_d == SRC_DTLB);
      if (pte_d.p) begin
        itlb_fill_en_d = (src_d == SRC_ITLB);
        dtlb_fill_en_d = (src_d == SRC_DTLB);
      end else begin
        page_fault_d = 1'b1;
        fault_src_d  = src_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      src_q          <= SRC_ITLB;
      last_src_q     <= SRC_DTLB;
      vpn_q          <= '0;
      pte_q          <= '0;
      itlb_idx_q     <= '0;
      dtlb_idx_q     <= '0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      fill_entry_q   <= '0;
      itlb_fill_en_q <= 1'b0;
      dtlb_fill_en_q <= 1'b0;
      itlb_done_q    <= 1'b0;
      dtlb_done_q    <= 1'b0;
      page_fault_q   <= 1'b0;
      fault_src_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      last_src_q     <= last_src_d;
      vpn_q          <= vpn_d;
      pte_q          <= pte_d;
      itlb_idx_q     <= itlb_idx_d;
      dtlb_idx_q     <= dtlb_idx_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      fill_entry_q   <= fill_entry_d;
      itlb_fill_en_q <= itlb_fill_en_d;
      dtlb_fill_en_q <= dtlb_fill_en_d;
      itlb_done_q    <= itlb_done_d;
      dtlb_done_q    <= dtlb_done_d;
      page_fault_q   <= page_fault_d;
      fault_src_q    <= fault_src_d;
    end
  end

  assign MEM_REQ       = mem_req_q;
  assign MEM_ADDR      = mem_addr_q;
  assign FILL_ENTRY    = fill_entry_q;
  assign ITLB_FILL_EN  = itlb_fill_en_q;
  assign DTLB_FILL_EN  = dtlb_fill_en_q;
  assign ITLB_FILL_IDX = itlb_idx_q;
  assign DTLB_FILL_IDX = dtlb_idx_q;
  assign ITLB_DONE     = itlb_done_q;
  assign DTLB_DONE     = dtlb_done_q;
  assign PAGE_FAULT    = page_fault_q;
  assign FAULT_SRC     = fault_src_q;

endmodule

// File: doc/tlb_fill_ctrl.md
# tlb_fill_ctrl

Miss-handling controller shared by the instruction TLB (in `ifu`) and the data TLB (in `lsu`). It arbitrates round-robin between ITLB and DTLB miss requests and fetches the page-table entry (PTE) over a single memory read port. It builds the 44-bit TLB entry and writes it into the requesting TLB at a per-TLB round-robin replacement index. A PTE that is not present raises a page-fault pulse instead of a fill.

## Interface
- `ENTRIES`, 8, TLB entries per TLB.
- `IDX_W`, 3, replacement index width (log2 `ENTRIES`).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `PTBR`  in  10  page-table base. PTE address = {PTBR, VPN, 2'b00}.
- `ITLB_MISS`  in  1  ITLB miss request; level, held until ITLB_DONE.
- `ITLB_VPN`  in  20  missing virtual page number (ITLB).
- `DTLB_MISS`  in  1  DTLB miss request; level, held until DTLB_DONE.
- `DTLB_VPN`  in  20  missing virtual page number (DTLB).
- `MEM_REQ`  out  1  PTE read request.
- `MEM_ADDR`  out  32  PTE byte address.
- `MEM_READY`  in  1  MEM_DATA valid; completes the read.
- `MEM_DATA`  in  32  PTE: [31:12] frame, [4] PCD, [1] R/W, [0] P.
- `FILL_ENTRY`  out  44  {VPN[19:0], PTE[31:12], 1'b1, PTE[0], PTE[1], PTE[4]} (VPN, RPN, V, PRE, R/W, PCD).
- `ITLB_FILL_EN` / `DTLB_FILL_EN`  out  1  write strobe into the selected TLB.
- `ITLB_FILL_IDX` / `DTLB_FILL_IDX`  out  IDX_W  entry index to write.
- `ITLB_DONE` / `DTLB_DONE`  out  1  one-cycle completion acknowledge.
- `PAGE_FAULT`  out  1  one-cycle pulse: PTE not present.
- `FAULT_SRC`  out  1  0 = ITLB, 1 = DTLB. Valid when PAGE_FAULT is high; holds otherwise.

## Operation
- The FSM has three states: IDLE, WALK, FILL.
- **IDLE**
  - If no MISS is asserted, stay in IDLE.
  - If exactly one MISS is asserted, grant that requester.
  - If both are asserted, grant the requester not served last. `last_src` resets to DTLB, so the ITLB wins the first tie.
  - On grant: latch the requester ID (`src`) and its VPN, and go to WALK.
- **WALK**
  - MEM_REQ = 1 and MEM_ADDR = {PTBR, vpn_q, 2'b00}. Both are held stable until MEM_READY.
  - On a clock edge with MEM_READY = 1: capture MEM_DATA into `pte_q` and go to FILL.
- **FILL** (exactly one cycle)
  - FILL_ENTRY is driven from `vpn_q` and `pte_q`.
  - If pte_q[0] = 1:
    - assert `<src>_FILL_EN` and `<src>_DONE`;
    - at the edge leaving FILL, increment `<src>` replacement counter (wraps 7→0).
  - If pte_q[0] = 0:
    - assert PAGE_FAULT and `<src>_DONE`, with FAULT_SRC = src;
    - no FILL_EN; the counter does not advance.
  - Update `last_src` = src, then return to IDLE.
- `ITLB_FILL_IDX` and `DTLB_FILL_IDX` always show the current counter values. Each counter resets to 0.
- A MISS deasserted during WALK does not abort the walk. The fill or fault and DONE still occur.
- A requester re-asserting MISS after its DONE is treated as a new request.
- FILL_ENTRY is a don't-care outside FILL; drive it from the registers anyway.
- PTBR is sampled combinationally during WALK. PTBR changes while busy are illegal.

## Timing
- Reset values (applied asynchronously while rst = 0):
  - state = IDLE;
  - MEM_REQ, all FILL_EN, all DONE and PAGE_FAULT = 0;
  - both counters = 0; last_src = DTLB;
  - MEM_ADDR = 0, FILL_ENTRY = 0, FAULT_SRC = 0.
- Reset asserted during WALK drops MEM_REQ immediately. No fill occurs and no DONE is issued. Requesters re-request after reset.
- Latency, with the MISS sampled at edge 0:
  - WALK spans edge 0 to edge 1, with MEM_REQ high;
  - MEM_READY high in that cycle gives FILL from edge 1 to edge 2;
  - IDLE at edge 2.
  - Minimum is 2 cycles from grant to DONE. Each wait cycle without READY adds 1.
- Back-to-back requests: the next grant is taken at the edge leaving IDLE, so there is one IDLE bubble between walks. Maximum throughput is one fill per 3 cycles.
- MEM_READY outside WALK is ignored.

## Test plan
- **Single ITLB fill.** PTBR = 0, ITLB_MISS with VPN = 20'h02000, MEM_READY on the first WALK cycle, MEM_DATA = 32'h00002003.
  - MEM_ADDR = 32'h00008000.
  - Next cycle: ITLB_FILL_EN = ITLB_DONE = 1, IDX = 0, FILL_ENTRY = {20'h02000, 20'h00002, 1, 1, 1, 0}.
  - ITLB counter becomes 1.
- **Simultaneous misses after reset.** ITLB VPN 20'h00000 and DTLB VPN 20'h04000, with READY immediate.
  - ITLB is served first; DTLB is walked starting 3 cycles after the first grant, with MEM_ADDR = 32'h00010000.
  - DTLB_FILL_IDX = 0.
- **Page fault.** DTLB_MISS, MEM_DATA = 32'h0002F002.
  - PAGE_FAULT = 1, FAULT_SRC = 1, DTLB_DONE = 1, no FILL_EN.
  - DTLB counter unchanged.
- **Replacement wrap.** 9 consecutive present ITLB fills.
  - Indices 0..7 then 0; DTLB_FILL_IDX stays 0 throughout.
- **Memory wait.** MEM_READY delayed 5 cycles.
  - MEM_REQ and MEM_ADDR are stable for 6 cycles; DONE follows in the cycle after READY.
  - A READY pulse while IDLE is ignored.
- **Reset mid-walk.** rst = 0 for one half-cycle during WALK.
  - MEM_REQ falls asynchronously; no DONE.
  - After release, the held MISS is re-granted and completes normally.
